// File: rtl/mmu_rsp_fifo_if.sv
// Write-strobe / FWFT read bundle between the MMU tree, the response FIFO
// and the host drain port.
interface mmu_rsp_fifo_if #(
   parameter int DATA_WIDTH = 32
);

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  almost_full;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_ready;

   modport master (
      output wr_en,
      output wr_data,
      output rd_ready,
      input  almost_full,
      input  rd_valid,
      input  rd_data
   );

   modport slave (
      input  wr_en,
      input  wr_data,
      input  rd_ready,
      output almost_full,
      output rd_valid,
      output rd_data
   );

endinterface

// File: rtl/mmu_rsp_fifo.sv
// MMU response FIFO: unconditional write strobes in, FWFT valid/ready out,
// registered almost_full back-pressure and sticky drop accounting.
module mmu_rsp_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int PTR_WIDTH  = 4,
   parameter int AF_MARGIN  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mmu_rsp_fifo_if.slave        bus,
   input  logic                 err_clr,
   output logic [PTR_WIDTH:0]   data_count,
   output logic                 overflow_err,
   output logic [7:0]           drop_count
);

   localparam logic [PTR_WIDTH:0]   FULL_LVL = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [PTR_WIDTH:0]   AF_LVL   = (PTR_WIDTH+1)'(DEPTH - AF_MARGIN);
   localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]   count_q, count_d;
   logic                 ovf_q, ovf_d;
   logic [7:0]           drop_cnt_q, drop_cnt_d;

   logic rd_fire;
   logic wr_acc;
   logic drop;

   // A full FIFO still accepts a write when the head leaves on the same edge.
   always_comb begin
      rd_fire = (count_q != '0) & bus.rd_ready;
      wr_acc  = bus.wr_en & ((count_q != FULL_LVL) | rd_fire);
      drop    = bus.wr_en & ~wr_acc;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({wr_acc, rd_fire})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // A drop in the same cycle as err_clr restarts the tally at one.
   always_comb begin
      ovf_d      = ovf_q;
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         ovf_d = 1'b1;
         if (err_clr) begin
            drop_cnt_d = 8'd1;
         end else if (drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
         end
      end else if (err_clr) begin
         ovf_d      = 1'b0;
         drop_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= 8'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is intentionally left out of reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= bus.wr_data;
      end
   end

   assign bus.rd_valid    = (count_q != '0);
   assign bus.rd_data     = mem_q[rd_ptr_q];
   assign bus.almost_full = (count_q >= AF_LVL);

   assign data_count   = count_q;
   assign overflow_err = ovf_q;
   assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_mmu_rsp_fifo.sv
// Directed plus randomized bench for mmu_rsp_fifo against a queue model.
// DATA_WIDTH=8, DEPTH=16, AF_MARGIN=4.
module tb_mmu_rsp_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       err_clr = 1'b0;
   logic [4:0] data_count;
   logic       overflow_err;
   logic [7:0] drop_count;

   mmu_rsp_fifo_if #(.DATA_WIDTH(8)) bus();

   mmu_rsp_fifo #(
      .DATA_WIDTH(8),
      .DEPTH(16),
      .PTR_WIDTH(4),
      .AF_MARGIN(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.slave),
      .err_clr(err_clr),
      .data_count(data_count),
      .overflow_err(overflow_err),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [7:0] mq[$];
   logic [7:0] outq[$];
   int         m_drops = 0;
   bit         m_ovf = 1'b0;
   int         max_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      chk("count", 32'(data_count), 32'(mq.size()));
      chk("rd_valid", 32'(bus.rd_valid), 32'(mq.size() != 0));
      if (mq.size() != 0)
         chk("rd_data", 32'(bus.rd_data), 32'(mq[0]));
      chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= 12));
      chk("overflow_err", 32'(overflow_err), 32'(m_ovf));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
   endtask

   task automatic step(input bit we, input logic [7:0] wd, input bit rr,
                       input bit clr);
      bit fire;
      bit acc;
      bus.wr_en    = we;
      bus.wr_data  = wd;
      bus.rd_ready = rr;
      err_clr      = clr;
      @(negedge clk);
      fire = (mq.size() != 0) && rr;
      if (fire) outq.push_back(bus.rd_data);
      acc = we && ((mq.size() < 16) || fire);
      @(posedge clk);
      #1;
      if (fire) void'(mq.pop_front());
      if (acc) mq.push_back(wd);
      if (we && !acc) begin
         m_ovf   = 1'b1;
         m_drops = clr ? 1 : ((m_drops < 255) ? m_drops + 1 : 255);
      end else if (clr) begin
         m_ovf   = 1'b0;
         m_drops = 0;
      end
      if (mq.size() > max_cnt) max_cnt = mq.size();
      check_state();
   endtask

   task automatic mid_reset();
      bus.wr_en    = 1'b0;
      bus.rd_ready = 1'b0;
      err_clr      = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
      check_state();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_state();
   endtask

   logic [7:0] exp_drain[17];
   int         sent;

   initial begin
      bus.wr_en    = 1'b0;
      bus.wr_data  = 8'h00;
      bus.rd_ready = 1'b0;

      // power-on reset
      repeat (2) @(posedge clk);
      #1;
      check_state();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // fill to almost_full, then to full
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 11) chk("af_at_11", 32'(bus.almost_full), 32'd0);
      end
      chk("af_at_12", 32'(bus.almost_full), 32'd1);
      for (int i = 13; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("full_count", 32'(data_count), 32'd16);
      chk("full_head", 32'(bus.rd_data), 32'h01);

      // overflow and clear
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("ovf_set", 32'(overflow_err), 32'd1);
      chk("ovf_drops", 32'(drop_count), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_ovf", 32'(overflow_err), 32'd0);
      chk("clr_drops", 32'(drop_count), 32'd0);
      step(1'b1, 8'hCC, 1'b0, 1'b1);
      chk("clr_vs_drop_ovf", 32'(overflow_err), 32'd1);
      chk("clr_vs_drop_cnt", 32'(drop_count), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // full with concurrent read and write
      outq.delete();
      step(1'b1, 8'hBB, 1'b1, 1'b0);
      chk("rw_full_count", 32'(data_count), 32'd16);
      for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) exp_drain[i] = 8'(i + 1);
      exp_drain[16] = 8'hBB;
      chk("drain_len", 32'(outq.size()), 32'd17);
      for (int i = 0; i < 17 && i < outq.size(); i++)
         chk("drain_word", 32'(outq[i]), 32'(exp_drain[i]));
      chk("drain_drops", 32'(drop_count), 32'd0);

      // wrap with random ready
      outq.delete();
      max_cnt = 0;
      sent = 0;
      for (int c = 0; c < 2000 && (sent < 40 || mq.size() != 0); c++) begin
         bit we;
         we = (sent < 40) && (mq.size() < 12) && ($urandom_range(0, 3) != 0);
         step(we, 8'(sent), 1'($urandom_range(0, 1)), 1'b0);
         if (we) sent++;
      end
      chk("wrap_timeout", 32'((sent == 40) && (mq.size() == 0)), 32'd1);
      chk("wrap_len", 32'(outq.size()), 32'd40);
      for (int i = 0; i < 40 && i < outq.size(); i++)
         chk("wrap_word", 32'(outq[i]), 32'(i));
      chk("wrap_max_cnt", 32'(max_cnt <= 16), 32'd1);
      chk("wrap_drops", 32'(drop_count), 32'd0);
      chk("wrap_empty", 32'(bus.rd_valid), 32'd0);

      // drop counter saturation
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("sat_drops", 32'(drop_count), 32'd255);
      chk("sat_ovf", 32'(overflow_err), 32'd1);
      chk("sat_head", 32'(bus.rd_data), 32'h50);

      // reset in the middle of a full, errored state
      mid_reset();
      chk("rst_count", 32'(data_count), 32'd0);
      chk("rst_af", 32'(bus.almost_full), 32'd0);

      // post-reset sanity
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      chk("post_rst_head", 32'(bus.rd_data), 32'h5A);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
